rwt_adc_capture_ctrl: RTL and testbench

Capture sequencer between the ADC sample register stage and the ADC-to-user async FIFO write port, in the adc_clk domain. Gates the free-running ADC sample stream into triggered bursts of programmable length. Frames each burst with first/last markers and counts samples dropped on backpressure. Optionally re-arms continuously with a programmable holdoff.

---
 rtl/rwt_adc_capture_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_rwt_adc_capture_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rwt_adc_capture_ctrl.sv
// ADC capture sequencer: gates the free-running sample stream into triggered,
// framed bursts toward the async FIFO write port, with drop accounting and
// optional continuous re-arm with holdoff.
module rwt_adc_capture_ctrl #(
  parameter  int unsigned LEN_W  = 16,
  parameter  int unsigned HOLD_W = 16,
  parameter  int unsigned OVF_W  = 16,
  localparam int unsigned DATA_W = 64,
  localparam int unsigned EN_W   = 4,
  localparam int unsigned BCNT_W = 32
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              cfg_enable,
  input  logic              cfg_continuous,
  input  logic [1:0]        cfg_trig_mode,
  input  logic [LEN_W-1:0]  cfg_burst_len,
  input  logic [HOLD_W-1:0] cfg_holdoff,
  input  logic              sw_trigger,
  input  logic              ext_trigger,
  input  logic              ovf_clr,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic [EN_W-1:0]   s_enables,
  input  logic              m_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic [EN_W-1:0]   m_enables,
  output logic              m_first,
  output logic              m_last,
  output logic              busy,
  output logic [1:0]        state,
  output logic              done,
  output logic [OVF_W-1:0]  ovf_count,
  output logic [BCNT_W-1:0] burst_count
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_t;

  localparam logic [1:0] TRIG_EXT = 2'd1;
  localparam logic [1:0] TRIG_SW  = 2'd2;

  state_t              state_q;
  state_t              state_d;
  logic                done_d;

  // Configuration captured at arm time
  logic [LEN_W-1:0]    len_q;
  logic [HOLD_W-1:0]   hold_q;
  logic                cont_q;
  logic [1:0]          mode_q;

  logic [LEN_W-1:0]    smp_cnt_q;
  logic [HOLD_W-1:0]   hold_cnt_q;
  logic                ext_q;

  logic                trig_fire;
  logic                accept;
  logic                drop;
  logic                burst_end;
  logic                arm_now;

  assign state = state_q;

  // Trigger qualification using the mode latched at arm time; reserved mode acts as immediate
  always_comb begin
    trig_fire = 1'b1;
    case (mode_q)
      TRIG_EXT: trig_fire = ext_trigger & ~ext_q;
      TRIG_SW:  trig_fire = sw_trigger;
      default:  trig_fire = 1'b1;
    endcase
  end

  // Output-register handshake: a sample is taken only if the holding register is free or draining
  always_comb begin
    accept    = (state_q == ST_CAPTURE) && s_valid && (!m_valid || m_ready);
    drop      = (state_q == ST_CAPTURE) && s_valid && m_valid && !m_ready;
    burst_end = accept && (smp_cnt_q == (len_q - LEN_W'(1)));
    arm_now   = (state_q == ST_IDLE) && (state_d == ST_ARMED);
  end

  // Next-state and completion-pulse logic
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_enable && (cfg_burst_len != '0)) begin
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (!cfg_enable) begin
          state_d = ST_IDLE;
        end else if (trig_fire) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        // A started burst always runs to its last word; enable only decides re-arm
        if (burst_end) begin
          if (cont_q && cfg_enable) begin
            state_d = (hold_q == '0) ? ST_ARMED : ST_HOLDOFF;
          end else begin
            state_d = ST_IDLE;
            done_d  = ~cont_q;
          end
        end
      end
      ST_HOLDOFF: begin
        if (!cfg_enable) begin
          state_d = ST_IDLE;
        end else if (hold_cnt_q == (hold_q - HOLD_W'(1))) begin
          state_d = ST_ARMED;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register, status flags and latched configuration
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      len_q   <= '0;
      hold_q  <= '0;
      cont_q  <= 1'b0;
      mode_q  <= 2'd0;
      ext_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != ST_IDLE);
      done    <= done_d;
      ext_q   <= ext_trigger;
      if (arm_now) begin
        len_q  <= cfg_burst_len;
        hold_q <= cfg_holdoff;
        cont_q <= cfg_continuous;
        mode_q <= cfg_trig_mode;
      end
    end
  end

  // Burst sample counter and holdoff timer
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      smp_cnt_q  <= '0;
      hold_cnt_q <= '0;
    end else begin
      if (state_q == ST_ARMED) begin
        smp_cnt_q <= '0;
      end else if (accept) begin
        smp_cnt_q <= smp_cnt_q + LEN_W'(1);
      end
      if (state_q == ST_HOLDOFF) begin
        hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
      end else begin
        hold_cnt_q <= '0;
      end
    end
  end

  // One-entry output holding register; keeps draining after CAPTURE is left
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_enables <= '0;
      m_first   <= 1'b0;
      m_last    <= 1'b0;
    end else if (accept) begin
      m_valid   <= 1'b1;
      m_data    <= s_data;
      m_enables <= s_enables;
      m_first   <= (smp_cnt_q == '0);
      m_last    <= burst_end;
    end else if (m_ready) begin
      m_valid   <= 1'b0;
      m_first   <= 1'b0;
      m_last    <= 1'b0;
    end
  end

  // Saturating drop counter (clear wins) and wrapping completed-burst counter
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      ovf_count   <= '0;
      burst_count <= '0;
    end else begin
      if (ovf_clr) begin
        ovf_count <= '0;
      end else if (drop && (ovf_count != '1)) begin
        ovf_count <= ovf_count + OVF_W'(1);
      end
      if (burst_end) begin
        burst_count <= burst_count + BCNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rwt_adc_capture_ctrl.sv
// Scoreboard bench for rwt_adc_capture_ctrl: a behavioural model fed by the
// stimulus process queues expected words; a negedge monitor pops and compares.
module tb_rwt_adc_capture_ctrl;

  logic        clk;
  logic        aresetn;
  logic        cfg_enable;
  logic        cfg_continuous;
  logic [1:0]  cfg_trig_mode;
  logic [15:0] cfg_burst_len;
  logic [15:0] cfg_holdoff;
  logic        sw_trigger;
  logic        ext_trigger;
  logic        ovf_clr;
  logic        s_valid;
  logic [63:0] s_data;
  logic [3:0]  s_enables;
  logic        m_ready;
  logic        m_valid;
  logic [63:0] m_data;
  logic [3:0]  m_enables;
  logic        m_first;
  logic        m_last;
  logic        busy;
  logic [1:0]  state;
  logic        done;
  logic [15:0] ovf_count;
  logic [31:0] burst_count;

  rwt_adc_capture_ctrl #(.LEN_W(16), .HOLD_W(16), .OVF_W(16)) dut (
    .clk(clk), .aresetn(aresetn),
    .cfg_enable(cfg_enable), .cfg_continuous(cfg_continuous),
    .cfg_trig_mode(cfg_trig_mode), .cfg_burst_len(cfg_burst_len),
    .cfg_holdoff(cfg_holdoff), .sw_trigger(sw_trigger),
    .ext_trigger(ext_trigger), .ovf_clr(ovf_clr),
    .s_valid(s_valid), .s_data(s_data), .s_enables(s_enables),
    .m_ready(m_ready), .m_valid(m_valid), .m_data(m_data),
    .m_enables(m_enables), .m_first(m_first), .m_last(m_last),
    .busy(busy), .state(state), .done(done),
    .ovf_count(ovf_count), .burst_count(burst_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  en;
    logic        first;
    logic        last;
  } word_t;

  word_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Observations gathered by the monitor for directed checks
  int n_hs = 0;
  int n_done = 0;
  int last_hold_run = 0;
  bit last_hs_first = 0;
  bit last_hs_last = 0;

  // Behavioural model: phase 0 idle, 1 waiting for trigger, 2 capturing, 3 holdoff
  int        m_ph = 0;
  bit        m_mv = 0;
  bit        m_done = 0;
  bit [15:0] m_ovf = 0;
  bit [31:0] m_bursts = 0;
  int        m_cnt = 0;
  int        m_hold_left = 0;
  bit        m_ext_prev = 0;
  int        l_len = 0;
  int        l_hold = 0;
  bit        l_cont = 0;
  int        l_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_ph = 0; m_mv = 0; m_done = 0; m_ovf = 0; m_bursts = 0;
    m_cnt = 0; m_hold_left = 0; m_ext_prev = 0;
    l_len = 0; l_hold = 0; l_cont = 0; l_mode = 0;
    exp_q.delete();
  endtask

  // Advance the model by one clock using the inputs present at the edge
  task automatic model_step();
    bit edge_s, drop, acc, trig;
    word_t w;
    if (!aresetn) begin
      model_reset();
      return;
    end
    edge_s = ext_trigger && !m_ext_prev;
    m_ext_prev = ext_trigger;
    drop = (m_ph == 2) && s_valid && m_mv && !m_ready;
    acc  = (m_ph == 2) && s_valid && (!m_mv || m_ready);
    if (ovf_clr) m_ovf = 0;
    else if (drop && m_ovf != 16'hFFFF) m_ovf = m_ovf + 16'd1;
    m_done = 0;
    if (acc) begin
      w.data = s_data; w.en = s_enables;
      w.first = (m_cnt == 0);
      w.last = (m_cnt + 1 == l_len);
      exp_q.push_back(w);
      m_mv = 1;
    end else if (m_ready) begin
      m_mv = 0;
    end
    case (m_ph)
      0: if (cfg_enable && cfg_burst_len != 16'd0) begin
        l_len = int'(cfg_burst_len); l_hold = int'(cfg_holdoff);
        l_cont = cfg_continuous; l_mode = int'(cfg_trig_mode);
        m_ph = 1;
      end
      1: if (!cfg_enable) m_ph = 0;
         else begin
           case (l_mode)
             1: trig = edge_s;
             2: trig = sw_trigger;
             default: trig = 1;
           endcase
           if (trig) begin m_ph = 2; m_cnt = 0; end
         end
      2: if (acc) begin
        m_cnt++;
        if (m_cnt == l_len) begin
          m_bursts = m_bursts + 32'd1;
          if (l_cont && cfg_enable) begin
            if (l_hold == 0) m_ph = 1;
            else begin m_ph = 3; m_hold_left = l_hold; end
          end else begin
            m_ph = 0;
            m_done = !l_cont;
          end
        end
      end
      3: if (!cfg_enable) m_ph = 0;
         else begin
           m_hold_left--;
           if (m_hold_left == 0) m_ph = 1;
         end
      default: ;
    endcase
  endtask

  // One clock: model sees the edge inputs, then fresh sample data is driven
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      #1;
      s_data = {$urandom, $urandom};
      s_enables = 4'($urandom);
    end
  endtask

  // Monitor: compare status every cycle and pop expected words on handshake
  initial begin : monitor
    int run;
    logic [1:0] prev_state;
    word_t w;
    run = 0;
    prev_state = 2'd0;
    forever begin
      @(negedge clk);
      check("state", 64'(state), 64'(m_ph));
      check("busy", 64'(busy), 64'(m_ph != 0));
      check("m_valid", 64'(m_valid), 64'(m_mv));
      check("done", 64'(done), 64'(m_done));
      check("ovf_count", 64'(ovf_count), 64'(m_ovf));
      check("burst_count", 64'(burst_count), 64'(m_bursts));
      if (m_valid && m_ready) begin
        n_hs++;
        check("word_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          check("m_data", m_data, w.data);
          check("m_enables", 64'(m_enables), 64'(w.en));
          check("m_first", 64'(m_first), 64'(w.first));
          check("m_last", 64'(m_last), 64'(w.last));
        end
        last_hs_first = m_first;
        last_hs_last = m_last;
      end
      if (done) n_done++;
      if (state == 2'd3) run++;
      else begin
        if (prev_state == 2'd3 && state == 2'd1) last_hold_run = run;
        run = 0;
      end
      prev_state = state;
    end
  end

  initial begin : stimulus
    int hs0, done0;
    cfg_enable = 0; cfg_continuous = 0; cfg_trig_mode = 0;
    cfg_burst_len = 0; cfg_holdoff = 0; sw_trigger = 0; ext_trigger = 0;
    ovf_clr = 0; s_valid = 0; s_data = 0; s_enables = 0; m_ready = 0;
    aresetn = 1;
    model_reset();
    #1 aresetn = 0;
    repeat (3) @(negedge clk);
    aresetn = 1;
    tick(2);

    // Immediate single-shot, len 4, always ready
    hs0 = n_hs; done0 = n_done;
    cfg_trig_mode = 2'd0; cfg_burst_len = 16'd4; cfg_continuous = 0;
    s_valid = 1; m_ready = 1; cfg_enable = 1;
    tick(2);
    cfg_enable = 0;
    tick(10);
    check("t1_words", 64'(n_hs - hs0), 64'd4);
    check("t1_done_pulses", 64'(n_done - done0), 64'd1);
    check("t1_bursts", 64'(burst_count), 64'd1);
    check("t1_idle", 64'(state), 64'd0);

    // External edge mode with trigger already high before arming
    hs0 = n_hs;
    ext_trigger = 1;
    tick(2);
    cfg_trig_mode = 2'd1; cfg_burst_len = 16'd3; cfg_enable = 1;
    tick(6);
    check("t2_still_armed", 64'(state), 64'd1);
    check("t2_no_words", 64'(n_hs - hs0), 64'd0);
    ext_trigger = 0;
    tick(1);
    ext_trigger = 1;
    tick(1);
    check("t2_capture_after_edge", 64'(state), 64'd2);
    cfg_enable = 0;
    tick(8);
    check("t2_words", 64'(n_hs - hs0), 64'd3);

    // Backpressure: three drops while a word is pending
    ovf_clr = 1; tick(1); ovf_clr = 0;
    hs0 = n_hs;
    cfg_trig_mode = 2'd0; cfg_burst_len = 16'd8; cfg_enable = 1; m_ready = 1;
    tick(2);
    cfg_enable = 0;
    tick(2);
    m_ready = 0;
    tick(3);
    m_ready = 1;
    tick(12);
    check("t3_ovf", 64'(ovf_count), 64'd3);
    check("t3_words", 64'(n_hs - hs0), 64'd8);

    // Continuous len 2 with holdoff 5
    cfg_burst_len = 16'd2; cfg_holdoff = 16'd5; cfg_continuous = 1; cfg_enable = 1;
    tick(40);
    cfg_enable = 0;
    tick(10);
    check("t4_holdoff_gap", 64'(last_hold_run), 64'd5);

    // Continuous len 1, holdoff 0: every word is both first and last
    cfg_burst_len = 16'd1; cfg_holdoff = 16'd0; cfg_enable = 1;
    tick(15);
    cfg_enable = 0;
    tick(5);
    check("t4_len1_first", 64'(last_hs_first), 64'd1);
    check("t4_len1_last", 64'(last_hs_last), 64'd1);

    // Enable dropped mid-burst of 6: framing completes
    hs0 = n_hs;
    cfg_continuous = 0; cfg_burst_len = 16'd6; cfg_enable = 1;
    tick(3);
    cfg_enable = 0;
    tick(12);
    check("t5_words", 64'(n_hs - hs0), 64'd6);
    check("t5_last_marked", 64'(last_hs_last), 64'd1);
    check("t5_idle", 64'(state), 64'd0);

    // Asynchronous reset in the middle of a burst
    cfg_enable = 1;
    tick(5);
    #2 aresetn = 0;
    model_reset();
    #1;
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_data", m_data, 64'd0);
    check("rst_m_enables", 64'(m_enables), 64'd0);
    check("rst_state", 64'(state), 64'd0);
    check("rst_burst_count", 64'(burst_count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    cfg_enable = 0;
    repeat (3) @(negedge clk);
    aresetn = 1;
    tick(2);

    // Overflow saturation, then clear coincident with a drop
    cfg_burst_len = 16'd4; cfg_enable = 1; m_ready = 0; s_valid = 1;
    tick(2);
    cfg_enable = 0;
    tick(65545);
    check("t6_ovf_saturated", 64'(ovf_count), 64'hFFFF);
    ovf_clr = 1;
    tick(1);
    ovf_clr = 0;
    check("t6_clr_wins", 64'(ovf_count), 64'd0);
    tick(1);
    m_ready = 1;
    tick(10);

    // Randomised configuration and handshake traffic
    for (int blk = 0; blk < 20; blk++) begin
      cfg_trig_mode = 2'($urandom_range(0, 3));
      cfg_burst_len = 16'($urandom_range(0, 5));
      cfg_holdoff = 16'($urandom_range(0, 3));
      cfg_continuous = 1'($urandom_range(0, 1));
      for (int c = 0; c < 40; c++) begin
        if ($urandom_range(0, 3) == 0) ext_trigger = ~ext_trigger;
        sw_trigger = ($urandom_range(0, 7) == 0);
        s_valid = ($urandom_range(0, 3) != 0);
        m_ready = ($urandom_range(0, 2) != 0);
        ovf_clr = ($urandom_range(0, 63) == 0);
        cfg_enable = ($urandom_range(0, 15) != 0);
        tick(1);
      end
    end

    // Drain everything and end idle
    cfg_enable = 0; sw_trigger = 0; ovf_clr = 0; s_valid = 1; m_ready = 1;
    tick(30);
    s_valid = 0;
    tick(3);
    check("end_queue_empty", 64'(exp_q.size()), 64'd0);
    check("end_idle", 64'(state), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
